tuple_in_sched: RTL and testbench

TUPLE_IN_SCHED -- requirements
Module: tuple_in_sched

---
 rtl/tuple_in_sched.sv | 130 +++++++++++++
 tb/tb_tuple_in_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tuple_in_sched.sv
// tuple_in_sched: passes an AXIS packet stream to the engine and queues each
// packet's first-beat tuser into a small tuple FIFO. Stalls SOP when the FIFO is full.
`default_nettype none

module tuple_in_sched #(
   parameter int DATA_W  = 256,
   parameter int TUSER_W = 128,
   parameter int DEPTH   = 4
) (
   input  logic                     tsc_aclk,
   input  logic                     tsc_arst,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic [DATA_W-1:0]        s_tdata,
   input  logic                     s_tlast,
   input  logic [TUSER_W-1:0]       s_tuser,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic                     m_tlast,
   output logic                     tup_valid,
   input  logic                     tup_ready,
   output logic [TUSER_W-1:0]       tup_data,
   output logic [$clog2(DEPTH):0]   tup_level,
   output logic [31:0]              pkt_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_SOP  = 2'd0,
      ST_BODY = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level;
   logic [TUSER_W-1:0] mem [DEPTH];
   logic               full;
   logic               accept;
   logic               push;
   logic               pop;

   // Full is judged on the registered level only; a same-cycle pop cannot unblock SOP.
   assign full      = (level == LVL_W'(DEPTH));
   assign accept    = s_tvalid & s_tready;
   assign push      = accept & (state == ST_SOP);
   assign tup_valid = (level != '0);
   assign pop       = tup_valid & tup_ready;
   assign tup_data  = mem[rd_ptr];
   assign tup_level = level;
   assign m_tdata   = s_tdata;
   assign m_tlast   = s_tlast;

   always_comb begin
      s_tready  = 1'b0;
      m_tvalid  = 1'b0;
      state_nxt = state;
      case (state)
         ST_SOP: begin
            if (!full) begin
               s_tready = m_tready;
               m_tvalid = s_tvalid;
            end
         end
         ST_BODY: begin
            s_tready = m_tready;
            m_tvalid = s_tvalid;
         end
         default: ;
      endcase
      if (tsc_arst) begin
         s_tready = 1'b0;
         m_tvalid = 1'b0;
      end
      case (state)
         ST_SOP: begin
            if (s_tvalid && s_tready)
               state_nxt = s_tlast ? ST_SOP : ST_BODY;
            else if (s_tvalid && full)
               state_nxt = ST_HOLD;
         end
         ST_BODY: begin
            if (s_tvalid && s_tready && s_tlast)
               state_nxt = ST_SOP;
         end
         ST_HOLD: begin
            if (!full)
               state_nxt = ST_SOP;
         end
         default: state_nxt = ST_SOP;
      endcase
   end

   always_ff @(posedge tsc_aclk or posedge tsc_arst) begin
      if (tsc_arst) begin
         state   <= ST_SOP;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         pkt_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         if (accept && s_tlast)
            pkt_cnt <= pkt_cnt + 32'd1;
      end
   end

   // Storage carries no reset; tup_data is only meaningful while tup_valid is high.
   always_ff @(posedge tsc_aclk) begin
      if (push)
         mem[wr_ptr] <= s_tuser;
   end

endmodule

`default_nettype wire

// File: tb/tb_tuple_in_sched.sv
// Directed self-checking bench for tuple_in_sched (DEPTH=4).
`default_nettype none

module tb_tuple_in_sched;
   localparam int DATA_W  = 256;
   localparam int TUSER_W = 128;
   localparam int DEPTH   = 4;

   logic               clk;
   logic               rst;
   logic               s_tvalid;
   logic               s_tready;
   logic [DATA_W-1:0]  s_tdata;
   logic               s_tlast;
   logic [TUSER_W-1:0] s_tuser;
   logic               m_tvalid;
   logic               m_tready;
   logic [DATA_W-1:0]  m_tdata;
   logic               m_tlast;
   logic               tup_valid;
   logic               tup_ready;
   logic [TUSER_W-1:0] tup_data;
   logic [2:0]         tup_level;
   logic [31:0]        pkt_cnt;

   int compared = 0;
   int mismatched = 0;
   int exp_pkts = 0;

   tuple_in_sched #(.DATA_W(DATA_W), .TUSER_W(TUSER_W), .DEPTH(DEPTH)) dut (
      .tsc_aclk (clk),
      .tsc_arst (rst),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tdata  (s_tdata),
      .s_tlast  (s_tlast),
      .s_tuser  (s_tuser),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tdata  (m_tdata),
      .m_tlast  (m_tlast),
      .tup_valid(tup_valid),
      .tup_ready(tup_ready),
      .tup_data (tup_data),
      .tup_level(tup_level),
      .pkt_cnt  (pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every task starts and ends at posedge+1; comb outputs are sampled at posedge+2.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1; tup_ready = 1'b0;
      s_tdata = '0; s_tlast = 1'b0; s_tuser = '0;
      step(); step();
      #1;
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
      compared++; if (m_tvalid !== 1'b0) begin mismatched++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
      compared++; if (tup_valid !== 1'b0) begin mismatched++; $display("FAIL rst_tup_valid: got %b want 0", tup_valid); end
      compared++; if (tup_level !== 3'd0) begin mismatched++; $display("FAIL rst_level: got %0d want 0", tup_level); end
      compared++; if (pkt_cnt !== 32'd0) begin mismatched++; $display("FAIL rst_pkt_cnt: got %0d want 0", pkt_cnt); end
      step();
      rst = 1'b0; s_tvalid = 1'b0;
      step();
   endtask

   task automatic test_three_beat();
      logic [DATA_W-1:0] d;
      tup_ready = 1'b0; m_tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = DATA_W'(32'h1000 + i);
         s_tvalid = 1'b1; s_tdata = d; s_tlast = (i == 2);
         s_tuser = (i == 0) ? TUSER_W'(8'hA5) : TUSER_W'(8'h50 + i);
         #1;
         compared++; if (s_tready !== 1'b1) begin mismatched++; $display("FAIL b3_s_tready[%0d]: got %b want 1", i, s_tready); end
         compared++; if (m_tvalid !== 1'b1) begin mismatched++; $display("FAIL b3_m_tvalid[%0d]: got %b want 1", i, m_tvalid); end
         compared++; if (m_tdata !== d) begin mismatched++; $display("FAIL b3_m_tdata[%0d]: got %h want %h", i, m_tdata, d); end
         compared++; if (m_tlast !== (i == 2)) begin mismatched++; $display("FAIL b3_m_tlast[%0d]: got %b want %b", i, m_tlast, (i == 2)); end
         step();
      end
      exp_pkts++;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd1) begin mismatched++; $display("FAIL b3_level: got %0d want 1", tup_level); end
      compared++; if (tup_valid !== 1'b1) begin mismatched++; $display("FAIL b3_tup_valid: got %b want 1", tup_valid); end
      compared++; if (tup_data !== TUSER_W'(8'hA5)) begin mismatched++; $display("FAIL b3_tup_data: got %h want a5", tup_data); end
      compared++; if (pkt_cnt !== 32'(exp_pkts)) begin mismatched++; $display("FAIL b3_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkts); end
      compared++; if (m_tvalid !== 1'b0) begin mismatched++; $display("FAIL b3_m_idle: got %b want 0", m_tvalid); end
      tup_ready = 1'b1;
      step();
      tup_ready = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd0) begin mismatched++; $display("FAIL b3_drain_level: got %0d want 0", tup_level); end
      step();
   endtask

   task automatic test_hold_full();
      tup_ready = 1'b0; m_tready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = DATA_W'(i); s_tuser = TUSER_W'(i);
         #1;
         compared++; if (s_tready !== 1'b1) begin mismatched++; $display("FAIL hold_fill_ready[%0d]: got %b want 1", i, s_tready); end
         step();
         exp_pkts++;
      end
      s_tuser = TUSER_W'(5); s_tdata = DATA_W'(5);
      #1;
      compared++; if (tup_level !== 3'd4) begin mismatched++; $display("FAIL hold_level_full: got %0d want 4", tup_level); end
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL hold_5th_ready: got %b want 0", s_tready); end
      compared++; if (m_tvalid !== 1'b0) begin mismatched++; $display("FAIL hold_5th_m_tvalid: got %b want 0", m_tvalid); end
      step();
      // now in HOLD; pop one
      tup_ready = 1'b1;
      #1;
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL hold_pop_cycle_ready: got %b want 0", s_tready); end
      step();
      tup_ready = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd3) begin mismatched++; $display("FAIL hold_level_after_pop: got %0d want 3", tup_level); end
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL hold_exit_cycle_ready: got %b want 0", s_tready); end
      compared++; if (tup_data !== TUSER_W'(2)) begin mismatched++; $display("FAIL hold_head: got %h want 2", tup_data); end
      step();
      #1;
      compared++; if (s_tready !== 1'b1) begin mismatched++; $display("FAIL hold_resume_ready: got %b want 1", s_tready); end
      step();
      exp_pkts++;
      // full at SOP with a same-cycle pop: beat must still be refused
      s_tuser = TUSER_W'(6); s_tdata = DATA_W'(6);
      tup_ready = 1'b1;
      #1;
      compared++; if (tup_level !== 3'd4) begin mismatched++; $display("FAIL full_pop_level_before: got %0d want 4", tup_level); end
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL full_pop_ready: got %b want 0", s_tready); end
      step();
      tup_ready = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd3) begin mismatched++; $display("FAIL full_pop_level_after: got %0d want 3", tup_level); end
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL full_pop_hold_ready: got %b want 0", s_tready); end
      step();
      #1;
      compared++; if (s_tready !== 1'b1) begin mismatched++; $display("FAIL full_pop_resume_ready: got %b want 1", s_tready); end
      step();
      exp_pkts++;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      tup_ready = 1'b1;
      for (int k = 3; k <= 6; k++) begin
         #1;
         compared++; if (tup_data !== TUSER_W'(k)) begin mismatched++; $display("FAIL hold_drain[%0d]: got %h want %h", k, tup_data, k); end
         step();
      end
      tup_ready = 1'b0;
      #1;
      compared++; if (tup_valid !== 1'b0) begin mismatched++; $display("FAIL hold_drained: got %b want 0", tup_valid); end
      compared++; if (pkt_cnt !== 32'(exp_pkts)) begin mismatched++; $display("FAIL hold_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkts); end
      step();
   endtask

   task automatic test_push_pop();
      tup_ready = 1'b0; m_tready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         s_tvalid = 1'b1; s_tlast = 1'b1; s_tuser = TUSER_W'(8'h21 + i);
         step();
         exp_pkts++;
      end
      tup_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_tuser = TUSER_W'(8'h23 + i);
         #1;
         compared++; if (tup_level !== 3'd2) begin mismatched++; $display("FAIL pp_level[%0d]: got %0d want 2", i, tup_level); end
         compared++; if (tup_data !== TUSER_W'(8'h21 + i)) begin mismatched++; $display("FAIL pp_order[%0d]: got %h want %h", i, tup_data, 8'h21 + i); end
         step();
         exp_pkts++;
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      for (int i = 5; i < 7; i++) begin
         #1;
         compared++; if (tup_data !== TUSER_W'(8'h21 + i)) begin mismatched++; $display("FAIL pp_tail[%0d]: got %h want %h", i, tup_data, 8'h21 + i); end
         step();
      end
      tup_ready = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd0) begin mismatched++; $display("FAIL pp_drained: got %0d want 0", tup_level); end
      step();
   endtask

   task automatic test_backpressure();
      tup_ready = 1'b0; m_tready = 1'b1;
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = DATA_W'(32'hB0); s_tuser = TUSER_W'(8'h41);
      step();
      s_tdata = DATA_W'(32'hB1); s_tuser = TUSER_W'(8'h77); m_tready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL bp_s_tready[%0d]: got %b want 0", i, s_tready); end
         compared++; if (m_tvalid !== 1'b1) begin mismatched++; $display("FAIL bp_m_tvalid[%0d]: got %b want 1", i, m_tvalid); end
         step();
      end
      m_tready = 1'b1;
      #1;
      compared++; if (s_tready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", s_tready); end
      compared++; if (m_tdata !== DATA_W'(32'hB1)) begin mismatched++; $display("FAIL bp_held_data: got %h want b1", m_tdata); end
      step();
      s_tdata = DATA_W'(32'hB2); s_tlast = 1'b1;
      step();
      exp_pkts++;
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd1) begin mismatched++; $display("FAIL bp_level: got %0d want 1", tup_level); end
      compared++; if (tup_data !== TUSER_W'(8'h41)) begin mismatched++; $display("FAIL bp_tup: got %h want 41", tup_data); end
      compared++; if (pkt_cnt !== 32'(exp_pkts)) begin mismatched++; $display("FAIL bp_pkt_cnt: got %0d want %0d", pkt_cnt, exp_pkts); end
      tup_ready = 1'b1;
      step();
      tup_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      tup_ready = 1'b0; m_tready = 1'b1;
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = TUSER_W'(8'h99);
      step();
      s_tuser = TUSER_W'(8'h98);
      step();
      rst = 1'b1;
      #1;
      compared++; if (tup_level !== 3'd0) begin mismatched++; $display("FAIL rm_level: got %0d want 0", tup_level); end
      compared++; if (pkt_cnt !== 32'd0) begin mismatched++; $display("FAIL rm_pkt_cnt: got %0d want 0", pkt_cnt); end
      compared++; if (s_tready !== 1'b0) begin mismatched++; $display("FAIL rm_s_tready: got %b want 0", s_tready); end
      compared++; if (tup_valid !== 1'b0) begin mismatched++; $display("FAIL rm_tup_valid: got %b want 0", tup_valid); end
      step();
      rst = 1'b0;
      s_tuser = TUSER_W'(8'h3C); s_tlast = 1'b1;
      #1;
      compared++; if (s_tready !== 1'b1) begin mismatched++; $display("FAIL rm_after_ready: got %b want 1", s_tready); end
      step();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      #1;
      compared++; if (tup_level !== 3'd1) begin mismatched++; $display("FAIL rm_push_level: got %0d want 1", tup_level); end
      compared++; if (tup_data !== TUSER_W'(8'h3C)) begin mismatched++; $display("FAIL rm_push_data: got %h want 3c", tup_data); end
      compared++; if (pkt_cnt !== 32'd1) begin mismatched++; $display("FAIL rm_push_cnt: got %0d want 1", pkt_cnt); end
      step();
   endtask

   initial begin
      test_reset();
      test_three_beat();
      test_hold_full();
      test_push_pop();
      test_backpressure();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
